// File: rtl/ldl_timer_arb_pkg.sv
// Shared types and constants for the shared-timer round-robin scheduler.
package ldl_timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  localparam int N_MIN     = 2;
  localparam int N_MAX     = 16;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/ldl_timer_arb_if.sv
// Requester-side bundle of the shared timer: requests/reloads in, ownership and count out.
interface ldl_timer_arb_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(N);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] load;
  logic               en;
  logic [N-1:0]       gnt;
  logic [N-1:0]       done;
  logic               busy;
  logic [WIDTH-1:0]   cnt;
  logic [IW-1:0]      owner;

  modport master (output req, load, en, input gnt, done, busy, cnt, owner);
  modport slave  (input req, load, en, output gnt, done, busy, cnt, owner);
endinterface

// File: rtl/ldl_rr_arb.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping at N.
module ldl_rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan farthest-first so the candidate closest to ptr overwrites the rest.
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ldl_timer_arb.sv
// One down-counter timer shared round-robin among N requesters; owner gets a done pulse on expiry.
module ldl_timer_arb
  import ldl_timer_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  ldl_timer_arb_if.slave bus
);

  localparam int IW = $clog2(N);

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("ldl_timer_arb: N out of range");
  end
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("ldl_timer_arb: WIDTH out of range");
  end

  logic [1:0]       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    owner;
  logic [WIDTH-1:0] cnt;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic             busy;

  logic             win_vld;
  logic [IW-1:0]    win;
  logic [N-1:0]     win_oh;
  logic [WIDTH-1:0] win_load;

  ldl_rr_arb #(.N(N), .IW(IW)) u_rr (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (win_vld),
    .idx   (win)
  );

  assign win_oh   = N'(1) << win;
  assign win_load = bus.load[win*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            gnt   <= win_oh;
            owner <= win;
            cnt   <= win_load;
            ptr   <= (win == IW'(N - 1)) ? '0 : win + 1'b1;
          end
        end
        ST_RUN: begin
          // Abort outranks expiry: a dropped request never sees done.
          if (!bus.req[owner]) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            gnt   <= '0;
          end else if (bus.en) begin
            if (cnt == '0) begin
              state <= ST_DONE;
              gnt   <= '0;
              done  <= gnt;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          gnt   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt;
  assign bus.done  = done;
  assign bus.busy  = busy;
  assign bus.cnt   = cnt;
  assign bus.owner = owner;

endmodule

// File: tb/tb_ldl_timer_arb.sv
// Randomized + directed bench for ldl_timer_arb with a transaction-level reference model and scoreboard.
module tb_ldl_timer_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = $clog2(N);

  typedef struct {
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic          busy;
    logic [W-1:0]  cnt;
    logic [IW-1:0] owner;
  } exp_t;

  logic clk;
  logic rst = 1'b1;

  ldl_timer_arb_if #(.N(N), .WIDTH(W)) bus ();

  ldl_timer_arb #(.N(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t q[$];
  int   gq[$];
  int   checks = 0;
  int   passes = 0;

  // Reference: who holds the timer, ticks left, who is being told it expired.
  int m_own  = -1;
  int m_fin  = -1;
  int m_left = 0;
  int m_last = 0;
  int m_next = 0;
  int ld[N];
  logic [N-1:0] r;

  task automatic model_step(input logic [N-1:0] rq, input logic e, input logic rs);
    exp_t x;
    if (rs) begin
      m_own = -1; m_fin = -1; m_left = 0; m_last = 0; m_next = 0;
    end else if (m_fin >= 0) begin
      m_fin = -1;
    end else if (m_own >= 0) begin
      if (!rq[m_own]) m_own = -1;
      else if (e) begin
        if (m_left == 0) begin
          m_fin = m_own;
          m_own = -1;
        end else m_left--;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_next + k) % N;
        if (rq[c] && m_own < 0) begin
          m_own = c; m_last = c; m_left = ld[c]; m_next = (c + 1) % N;
        end
      end
    end
    x.gnt  = '0;
    x.done = '0;
    if (m_own >= 0) x.gnt[m_own] = 1'b1;
    if (m_fin >= 0) x.done[m_fin] = 1'b1;
    x.busy  = (m_own >= 0) || (m_fin >= 0);
    x.cnt   = W'(m_left);
    x.owner = IW'(m_last);
    q.push_back(x);
  endtask

  // Drive one cycle of inputs (sampled at the next rising edge) and predict its outcome.
  task automatic cyc(input logic [N-1:0] rq, input logic e, input logic rs);
    @(negedge clk);
    bus.req = rq;
    bus.en  = e;
    rst     = rs;
    for (int i = 0; i < N; i++) bus.load[i*W +: W] = W'(ld[i]);
    model_step(rq, e, rs);
  endtask

  task automatic agent(input int p_raise, input int p_abort, input int p_en,
                       input int ldmax, input int p_rst);
    logic e, rs;
    for (int i = 0; i < N; i++) begin
      if (m_fin == i) r[i] = 1'b0;
      else if (r[i]) begin
        if (int'($urandom_range(99)) < p_abort) r[i] = 1'b0;
      end else if (int'($urandom_range(99)) < p_raise) r[i] = 1'b1;
      if (ldmax > 0 && $urandom_range(49) == 0) ld[i] = (1 << W) - 1;
      else ld[i] = int'($urandom_range(ldmax));
    end
    e  = int'($urandom_range(99)) < p_en;
    rs = int'($urandom_range(999)) < p_rst;
    cyc(r, e, rs);
  endtask

  logic [N-1:0] prev_gnt = '0;
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (bus.gnt === x.gnt && bus.done === x.done && bus.busy === x.busy &&
            bus.cnt === x.cnt && bus.owner === x.owner)
          passes++;
        else
          $display("FAIL outputs @%0t: got gnt=%b done=%b busy=%b cnt=%0d owner=%0d, want gnt=%b done=%b busy=%b cnt=%0d owner=%0d",
                   $time, bus.gnt, bus.done, bus.busy, bus.cnt, bus.owner,
                   x.gnt, x.done, x.busy, x.cnt, x.owner);
        if (prev_gnt == '0 && bus.gnt != '0) gq.push_back(int'(bus.owner));
        prev_gnt = bus.gnt;
      end
    end
  end

  initial begin
    int en_seq[5];
    int order[5];
    bus.req  = '0;
    bus.en   = 1'b0;
    bus.load = '0;
    for (int i = 0; i < N; i++) ld[i] = 0;
    en_seq = '{1, 0, 1, 0, 1};
    order  = '{0, 1, 2, 3, 0};

    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b1);

    // Single client, reload 3.
    ld[2] = 3;
    repeat (5) cyc(4'b0100, 1'b1, 1'b0);
    repeat (2) cyc(4'b0000, 1'b1, 1'b0);

    // Abort at cnt=6 with client 3 pending.
    ld[1] = 10; ld[3] = 5;
    cyc(4'b0010, 1'b1, 1'b0);
    repeat (4) cyc(4'b1010, 1'b1, 1'b0);
    cyc(4'b1000, 1'b1, 1'b0);
    cyc(4'b1000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);

    // Tick gating, reload 2; load change after grant must not matter.
    ld[0] = 2;
    cyc(4'b0001, 1'b1, 1'b0);
    ld[0] = 200;
    foreach (en_seq[k]) cyc(4'b0001, en_seq[k] != 0, 1'b0);
    repeat (2) cyc(4'b0000, 1'b1, 1'b0);

    // Abort in the same cycle the count would expire.
    ld[2] = 0;
    cyc(4'b0100, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);

    // Reset in the middle of a run, then arbitration restarts from client 0.
    ld[0] = 9;
    cyc(4'b0001, 1'b1, 1'b0);
    repeat (4) cyc(4'b0001, 1'b1, 1'b0);
    cyc(4'b1010, 1'b1, 1'b1);
    cyc(4'b1010, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);

    // Fairness: everyone requests, zero reloads, re-raise right after done.
    cyc('0, 1'b1, 1'b1);
    gq.delete();
    r = '1;
    repeat (16) agent(100, 0, 100, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k < gq.size() && gq[k] == order[k]) passes++;
      else $display("FAIL grant_order[%0d]: got %0d, want %0d (grants seen %0d)",
                    k, (k < gq.size()) ? gq[k] : -1, order[k], gq.size());
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) agent(30, 3, 75, 12, 3);

    r = '0;
    repeat (4) cyc(r, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
